// File: rtl/sync_pkg.sv
// Shared defaults and helpers for the multi-channel synchronizer/filter.
package sync_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_STAGES   = 2;
  localparam int DEF_FILT_CNT = 3;

  // Stability counter width; never below one bit so declarations stay legal.
  function automatic int cnt_width(input int filt_cnt);
    return (filt_cnt < 1) ? 1 : $clog2(filt_cnt + 1);
  endfunction

endpackage

// File: rtl/sync_bit_filter.sv
// One channel: flop-chain synchronizer, stability filter and edge pulses.
module sync_bit_filter
  import sync_pkg::*;
#(
  parameter int STAGES   = DEF_STAGES,
  parameter int FILT_CNT = DEF_FILT_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] sync_q;
  logic filt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

  generate
    if (FILT_CNT == 0) begin : g_bypass
      assign filt_out  = sync_q[STAGES-1];
      assign filt_next = sync_q[STAGES-2];
    end else begin : g_filter
      localparam int CW = cnt_width(FILT_CNT);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          filt_q;
      logic          filt_d;

      // Accept the new level on the F-th consecutive mismatching cycle.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[STAGES-1] != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync_q[STAGES-1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt_out  = filt_q;
      assign filt_next = filt_d;
    end
  endgenerate

  // Pulses register alongside filt_out so they coincide with its new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= filt_next & ~filt_out;
      fall_pulse <= ~filt_next & filt_out;
    end
  end

endmodule

// File: rtl/multi_sync_filter.sv
// WIDTH independent synchronized, glitch-filtered channels with edge pulses.
module multi_sync_filter
  import sync_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STAGES   = DEF_STAGES,
  parameter int FILT_CNT = DEF_FILT_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_bit_filter #(
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT)
    ) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (async_in[i]),
      .sync_out   (sync_out[i]),
      .filt_out   (filt_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multi_sync_filter.sv
// Bench for multi_sync_filter: default build plus a bypass/3-stage build.
module tb_multi_sync_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] ain_a;
  logic [3:0] so_a, fo_a, rp_a, fp_a;
  logic       ac_a;
  logic       ain_b;
  logic       so_b, fo_b, rp_b, fp_b;
  logic       ac_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  multi_sync_filter dut_a (
    .clk(clk), .rst_n(rst_n), .async_in(ain_a), .sync_out(so_a),
    .filt_out(fo_a), .rise_pulse(rp_a), .fall_pulse(fp_a), .any_change(ac_a)
  );

  multi_sync_filter #(.WIDTH(1), .STAGES(3), .FILT_CNT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .async_in(ain_b), .sync_out(so_b),
    .filt_out(fo_b), .rise_pulse(rp_b), .fall_pulse(fp_b), .any_change(ac_b)
  );

  // Reference: per-edge input history; sync is the input sampled STAGES-1
  // edges ago; filt flips when the last F visible sync values all differ.
  logic [3:0] ih [2][16];
  logic [3:0] sh [2][16];
  logic [3:0] m_sync [2];
  logic [3:0] m_filt [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];

  task automatic model_step(input int m, input int s, input int f,
                            input logic rst, input logic [3:0] ain);
    logic [3:0] ns;
    logic [3:0] nf;
    bit         all_diff;
    if (!rst) begin
      for (int j = 0; j < 16; j++) begin
        ih[m][j] = 4'h0;
        sh[m][j] = 4'h0;
      end
      m_sync[m] = 4'h0;
      m_filt[m] = 4'h0;
      m_rise[m] = 4'h0;
      m_fall[m] = 4'h0;
    end else begin
      for (int j = 0; j < 15; j++) ih[m][j] = ih[m][j+1];
      ih[m][15] = ain;
      ns = ih[m][16-s];
      nf = m_filt[m];
      for (int i = 0; i < 4; i++) begin
        if (f == 0) begin
          nf[i] = ns[i];
        end else begin
          all_diff = 1'b1;
          for (int j = 0; j < f; j++)
            if (sh[m][15-j][i] == m_filt[m][i]) all_diff = 1'b0;
          if (all_diff) nf[i] = ~m_filt[m][i];
        end
      end
      for (int j = 0; j < 15; j++) sh[m][j] = sh[m][j+1];
      sh[m][15] = ns;
      m_rise[m] = nf & ~m_filt[m];
      m_fall[m] = ~nf & m_filt[m];
      m_filt[m] = nf;
      m_sync[m] = ns;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 2, 3, rst_n, ain_a);
    model_step(1, 3, 0, rst_n, {3'b000, ain_b});
    @(negedge clk);
    cyc++;
    check("a_sync", so_a, m_sync[0]);
    check("a_filt", fo_a, m_filt[0]);
    check("a_rise", rp_a, m_rise[0]);
    check("a_fall", fp_a, m_fall[0]);
    check("a_any", {3'b000, ac_a}, {3'b000, |(m_rise[0] | m_fall[0])});
    check("a_excl", rp_a & fp_a, 4'h0);
    check("b_sync", {3'b000, so_b}, m_sync[1]);
    check("b_filt", {3'b000, fo_b}, m_filt[1]);
    check("b_rise", {3'b000, rp_b}, m_rise[1]);
    check("b_fall", {3'b000, fp_b}, m_fall[1]);
    check("b_any", {3'b000, ac_b}, {3'b000, |(m_rise[1] | m_fall[1])});
    if (cyc % 4 == 0) ain_b = ~ain_b;
  endtask

  int cnt_r, cnt_f, cnt_x;

  initial begin
    rst_n = 1'b0;
    ain_a = 4'h0;
    ain_b = 1'b0;
    repeat (3) tick();
    check("rst_sync", so_a, 4'h0);
    check("rst_filt", fo_a, 4'h0);
    check("rst_pulse", rp_a | fp_a, 4'h0);

    rst_n = 1'b1;
    repeat (4) tick();

    // Single channel latency: sync after 2 edges, filt and pulse after 5.
    ain_a = 4'b0001;
    tick(); check("lat1_sync", so_a, 4'b0000);
    tick(); check("lat2_sync", so_a, 4'b0001);
    tick(); tick(); check("lat4_filt", fo_a, 4'b0000);
    tick();
    check("lat5_filt", fo_a, 4'b0001);
    check("lat5_rise", rp_a, 4'b0001);
    check("lat5_any", {3'b000, ac_a}, 4'b0001);
    tick();
    check("lat6_rise", rp_a, 4'b0000);
    check("lat6_any", {3'b000, ac_a}, 4'b0000);

    // Two-cycle glitch on channel 1 must be swallowed.
    ain_a = 4'b0011;
    tick(); tick();
    ain_a = 4'b0001;
    cnt_x = 0;
    repeat (10) begin
      tick();
      check("glitch_filt", fo_a, 4'b0001);
      if ((rp_a | fp_a) != 4'h0) cnt_x++;
    end
    check("glitch_pulses", 4'(cnt_x), 4'd0);

    // Simultaneous events on all channels.
    ain_a = 4'h0;
    repeat (8) tick();
    ain_a = 4'hf;
    cnt_r = 0;
    repeat (10) begin
      tick();
      if (rp_a == 4'hf) cnt_r++;
    end
    check("sim_rise_once", 4'(cnt_r), 4'd1);
    ain_a = 4'h5;
    cnt_f = 0;
    cnt_x = 0;
    repeat (10) begin
      tick();
      if (fp_a == 4'ha) cnt_f++;
      if (rp_a != 4'h0) cnt_x++;
    end
    check("sim_fall_once", 4'(cnt_f), 4'd1);
    check("sim_no_rise", 4'(cnt_x), 4'd0);

    // Reset while channel 0 counter sits at 2.
    ain_a = 4'h0;
    repeat (8) tick();
    ain_a = 4'b0001;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_sync", so_a, 4'h0);
    check("mid_rst_filt", fo_a, 4'h0);
    check("mid_rst_pulse", rp_a | fp_a, 4'h0);
    rst_n = 1'b1;
    tick(); check("rel1_pulse", rp_a | fp_a, 4'h0);
    tick(); tick(); tick(); check("rel4_filt", fo_a, 4'b0000);
    tick();
    check("rel5_filt", fo_a, 4'b0001);
    check("rel5_rise", rp_a, 4'b0001);

    // Random levels with random hold times on every channel.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) ain_a = 4'($urandom_range(0, 15));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_sync_filter.md
MULTI_SYNC_FILTER -- requirements
Module: multi_sync_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent single-bit channels, 1..32.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel, minimum 2.
REQ-003 Parameter FILT_CNT, default 3: consecutive stable cycles required before the filtered output changes; 0 = filter bypassed.
REQ-004 clk  input  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 async_in  input  WIDTH  asynchronous level inputs from a foreign domain or pins.
REQ-007 sync_out  output  WIDTH  per-channel output of the last synchronizer stage.
REQ-008 filt_out  output  WIDTH  per-channel glitch-filtered level.
REQ-009 rise_pulse  output  WIDTH  one-cycle pulse on a filt_out 0->1 transition.
REQ-010 fall_pulse  output  WIDTH  one-cycle pulse on a filt_out 1->0 transition.
REQ-011 any_change  output  1  OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each channel SHALL pass async_in[i] through a chain of STAGES flops; sync_out[i] SHALL be the last stage, with no logic between stages.
REQ-013 A level change on async_in[i] that is stable before edge 1 SHALL appear on sync_out[i] after exactly STAGES rising edges.
REQ-014 Each channel SHALL hold a stability counter of width clog2(FILT_CNT+1); a cycle with sync_out[i] == filt_out[i] SHALL clear the counter to 0.
REQ-015 While sync_out[i] != filt_out[i], the counter SHALL increment once per cycle; on the edge at which it would reach FILT_CNT, filt_out[i] SHALL take sync_out[i] and the counter SHALL clear to 0.
REQ-016 End-to-end latency from async_in change to filt_out change SHALL be STAGES+FILT_CNT cycles.
REQ-017 A mismatch lasting fewer than FILT_CNT cycles SHALL leave filt_out unchanged and produce no pulse.
REQ-018 With FILT_CNT=0, filt_out SHALL equal sync_out and no counter SHALL be instantiated.
REQ-019 rise_pulse[i] SHALL be high for exactly the first cycle in which filt_out[i] reads 1 after reading 0.
REQ-020 fall_pulse[i] SHALL be high for exactly the first cycle in which filt_out[i] reads 0 after reading 1.
REQ-021 rise_pulse[i] and fall_pulse[i] SHALL never be high together.
REQ-022 Pulse outputs SHALL be registered.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse in their own bit in the same cycle.
REQ-024 any_change SHALL be the combinational OR of the registered pulse bits.
REQ-025 The counter SHALL saturate, never wrap: it is cleared at FILT_CNT.

Reset
REQ-026 With rst_n=0 at a rising edge, all synchronizer flops, counters, sync_out, filt_out, rise_pulse and fall_pulse SHALL become 0 on that edge.
REQ-027 Reset asserted mid-filtering SHALL discard partial counts.
REQ-028 The first cycle after reset release SHALL produce no pulse, even if async_in is already 1.
REQ-029 When async_in is already 1 at reset release, a rise_pulse SHALL follow only after STAGES+FILT_CNT cycles.
REQ-030 No asynchronous reset path SHALL exist.

Structure
REQ-031 A shared package sync_pkg SHALL hold the default constants (DEF_WIDTH=4, DEF_STAGES=2, DEF_FILT_CNT=3) and the counter-width function.
REQ-032 One sub-module, sync_bit_filter, SHALL implement a single channel (synchronizer, counter, filt_out, pulses).
REQ-033 The top SHALL generate WIDTH instances of sync_bit_filter plus the any_change OR.
REQ-034 Synchronizer flops SHALL carry a synthesis keep/ASYNC_REG attribute.

Verification
REQ-035 Defaults; async_in 0000->0001 held → sync_out[0]=1 after 2 cycles, filt_out[0]=1 after 5 cycles, rise_pulse=0001 and any_change=1 for exactly cycle 5.
REQ-036 Glitch: async_in[1] high for 2 cycles, then low → filt_out, rise_pulse and fall_pulse stay 0000 throughout.
REQ-037 Simultaneous events: async_in 0000->1111, later 1111->0101 → rise_pulse=1111 in one cycle; later fall_pulse=1010 in one cycle, with no rise.
REQ-038 Reset mid-operation: rst_n=0 for 1 cycle at count 2 while async_in=1 → all outputs 0; filt_out=1 exactly 5 cycles after release; no pulse in the first cycle after release.
REQ-039 Bypass and depth: FILT_CNT=0, STAGES=3, WIDTH=1; toggle every 4 cycles → filt_out equals sync_out, lags by 3 cycles, and one pulse per toggle.
REQ-040 Assertion, checked over random stimulus on all channels: rise_pulse & fall_pulse == 0 on every cycle.
